// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources,
// with per-requester grant lock, inter-byte gap and busy-timeout recovery.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_lock_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic                 uart_ss_o,
  output logic [7:0]           uart_data_o,
  input  logic                 uart_busy_i,
  output logic [2:0]           owner_o,
  output logic                 active_o,
  output logic                 timeout_err_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam int BW = $clog2(BUSY_TIMEOUT);

  logic [2:0]         state_q, state_d;
  logic [2:0]         owner_q, owner_d;
  logic [7:0]         data_q, data_d;
  logic               ss_q, ss_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               active_q, active_d;
  logic               tout_q, tout_d;
  logic [BW-1:0]      busyCnt_q, busyCnt_d;
  logic [7:0]         gapCnt_q, gapCnt_d;

  logic [2:0]         winner, hiIdx, loIdx;
  logic               hiFound;
  logic [7:0]         winData, ownData;
  logic               ownReq, ownLock, endGap;
  logic [NUM_REQ-1:0] ownOneHot;

  // Winner is the lowest requester above the owner, else the lowest overall.
  always_comb begin
    hiIdx   = '0;
    loIdx   = '0;
    hiFound = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        loIdx = 3'(i);
        if (3'(i) > owner_q) begin
          hiIdx   = 3'(i);
          hiFound = 1'b1;
        end
      end
    end
    winner = hiFound ? hiIdx : loIdx;
  end

  always_comb begin
    winData   = '0;
    ownData   = '0;
    ownReq    = 1'b0;
    ownLock   = 1'b0;
    ownOneHot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == winner) winData = req_data_i[8*i +: 8];
      if (3'(i) == owner_q) begin
        ownData      = req_data_i[8*i +: 8];
        ownReq       = req_i[i];
        ownLock      = req_lock_i[i];
        ownOneHot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    data_d    = data_q;
    ss_d      = 1'b0;
    ack_d     = '0;
    active_d  = active_q;
    tout_d    = 1'b0;
    busyCnt_d = busyCnt_q;
    gapCnt_d  = gapCnt_q;
    endGap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          owner_d = winner;
          data_d  = winData;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        ss_d      = 1'b1;
        ack_d     = ownOneHot;
        active_d  = 1'b1;
        busyCnt_d = '0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_busy_i) begin
          state_d = WAIT_DONE;
        end else if (busyCnt_q == BW'(BUSY_TIMEOUT - 1)) begin
          tout_d   = 1'b1;
          gapCnt_d = '0;
          state_d  = GAP;
          endGap   = (GAP_CYCLES == 0);
        end else begin
          busyCnt_d = busyCnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy_i) begin
          gapCnt_d = '0;
          state_d  = GAP;
          endGap   = (GAP_CYCLES == 0);
        end
      end
      GAP: begin
        if (int'(gapCnt_q) >= GAP_CYCLES - 1) endGap = 1'b1;
        else gapCnt_d = gapCnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A locked owner with a byte still pending skips arbitration entirely.
    if (endGap) begin
      if (ownLock && ownReq) begin
        data_d  = ownData;
        state_d = LAUNCH;
      end else begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      owner_q   <= 3'(NUM_REQ - 1);
      data_q    <= '0;
      ss_q      <= 1'b0;
      ack_q     <= '0;
      active_q  <= 1'b0;
      tout_q    <= 1'b0;
      busyCnt_q <= '0;
      gapCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      data_q    <= data_d;
      ss_q      <= ss_d;
      ack_q     <= ack_d;
      active_q  <= active_d;
      tout_q    <= tout_d;
      busyCnt_q <= busyCnt_d;
      gapCnt_q  <= gapCnt_d;
    end
  end

  assign ack_o         = ack_q;
  assign uart_ss_o     = ss_q;
  assign uart_data_o   = data_q;
  assign owner_o       = owner_q;
  assign active_o      = active_q;
  assign timeout_err_o = tout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, single byte, round-robin, lock,
// busy timeout and reset mid-transfer, with a simple UART busy responder.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        reset_i;
  logic [3:0]  req_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_lock_i;
  logic [3:0]  ack_o;
  logic        uart_ss_o;
  logic [7:0]  uart_data_o;
  logic        uart_busy_i;
  logic [2:0]  owner_o;
  logic        active_o;
  logic        timeout_err_o;

  int checkCount = 0;
  int failCount  = 0;
  int ackSeen    = 0;
  int ssSeen     = 0;
  int ackStray   = 0;
  int multiAck   = 0;
  bit busyModelOn = 1'b1;
  bit risePending = 1'b0;
  int busyLeft    = 0;
  bit ok;

  uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(2), .BUSY_TIMEOUT(64)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .req_data_i(req_data_i),
    .req_lock_i(req_lock_i), .ack_o(ack_o), .uart_ss_o(uart_ss_o),
    .uart_data_o(uart_data_o), .uart_busy_i(uart_busy_i), .owner_o(owner_o),
    .active_o(active_o), .timeout_err_o(timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART responder: busy rises one clock after ss and stays high for 10 clocks.
  always @(negedge clk) begin
    if (reset_i) begin
      uart_busy_i = 1'b0;
      busyLeft    = 0;
      risePending = 1'b0;
    end else begin
      if (risePending) begin
        uart_busy_i = 1'b1;
        busyLeft    = 10;
        risePending = 1'b0;
      end else if (busyLeft > 0) begin
        busyLeft = busyLeft - 1;
        if (busyLeft == 0) uart_busy_i = 1'b0;
      end
      if (busyModelOn && uart_ss_o) risePending = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (uart_ss_o) ssSeen++;
    if (ack_o != 4'b0) begin
      ackSeen++;
      if (!uart_ss_o) ackStray++;
      if ($countones(ack_o) > 1) multiAck++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock);
    req_i      = req;
    req_lock_i = lock;
  endtask

  task automatic setData(input int idx, input logic [7:0] val);
    req_data_i[8*idx +: 8] = val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitSs(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (uart_ss_o) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitIdle(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!active_o) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic resetPulse(input string tag);
    reset_i = 1'b1;
    tick();
    tick();
    checkOutput(tag, 32'(owner_o), 32'd3);
    reset_i = 1'b0;
  endtask

  initial begin
    logic [7:0] lockData [4];
    logic [3:0] lockAck  [4];
    lockData[0] = 8'hA0; lockData[1] = 8'hA1; lockData[2] = 8'hA2; lockData[3] = 8'hC2;
    lockAck[0]  = 4'b0001; lockAck[1] = 4'b0001; lockAck[2] = 4'b0001; lockAck[3] = 4'b0100;

    reset_i     = 1'b1;
    uart_busy_i = 1'b0;
    req_data_i  = '0;
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] reset state");
    tick();
    tick();
    checkOutput("rst ss", 32'(uart_ss_o), 32'd0);
    checkOutput("rst ack", 32'(ack_o), 32'd0);
    checkOutput("rst owner", 32'(owner_o), 32'd3);
    checkOutput("rst active", 32'(active_o), 32'd0);
    checkOutput("rst tout", 32'(timeout_err_o), 32'd0);
    checkOutput("rst data", 32'(uart_data_o), 32'd0);
    reset_i = 1'b0;
    repeat (5) tick();
    checkOutput("idle active", 32'(active_o), 32'd0);
    checkOutput("idle ss", 32'(uart_ss_o), 32'd0);
    checkOutput("idle owner", 32'(owner_o), 32'd3);

    $display("[TB] single byte");
    setData(0, 8'h23);
    applyStimulus(4'b0001, 4'b0000);
    tick();
    checkOutput("single ss early", 32'(uart_ss_o), 32'd0);
    tick();
    checkOutput("single ss", 32'(uart_ss_o), 32'd1);
    checkOutput("single data", 32'(uart_data_o), 32'h23);
    checkOutput("single ack", 32'(ack_o), 32'b0001);
    checkOutput("single owner", 32'(owner_o), 32'd0);
    checkOutput("single active", 32'(active_o), 32'd1);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("single ss pulse", 32'(uart_ss_o), 32'd0);
    checkOutput("single ack pulse", 32'(ack_o), 32'd0);
    repeat (12) tick();
    checkOutput("single active in gap", 32'(active_o), 32'd1);
    tick();
    checkOutput("single active end", 32'(active_o), 32'd0);

    $display("[TB] round robin");
    resetPulse("rr reset owner");
    for (int i = 0; i < 4; i++) setData(i, 8'(8'h10 + i));
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      waitSs(40, ok);
      checkOutput($sformatf("rr ss %0d", k), 32'(ok), 32'd1);
      checkOutput($sformatf("rr data %0d", k), 32'(uart_data_o), 32'(8'h10 + (k % 4)));
      checkOutput($sformatf("rr ack %0d", k), 32'(ack_o), 32'(1 << (k % 4)));
    end
    applyStimulus(4'b0000, 4'b0000);
    waitIdle(40, ok);
    checkOutput("rr idle", 32'(ok), 32'd1);

    $display("[TB] lock");
    resetPulse("lock reset owner");
    setData(0, 8'hA0);
    setData(2, 8'hC2);
    applyStimulus(4'b0101, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      waitSs(40, ok);
      checkOutput($sformatf("lock ss %0d", k), 32'(ok), 32'd1);
      checkOutput($sformatf("lock data %0d", k), 32'(uart_data_o), 32'(lockData[k]));
      checkOutput($sformatf("lock ack %0d", k), 32'(ack_o), 32'(lockAck[k]));
      if (k == 0) setData(0, 8'hA1);
      if (k == 1) setData(0, 8'hA2);
      if (k == 2) applyStimulus(4'b0100, 4'b0001);
      if (k == 3) applyStimulus(4'b0000, 4'b0000);
    end
    waitIdle(40, ok);
    checkOutput("lock idle", 32'(ok), 32'd1);

    $display("[TB] busy timeout");
    busyModelOn = 1'b0;
    setData(1, 8'h4B);
    applyStimulus(4'b0010, 4'b0000);
    waitSs(40, ok);
    checkOutput("tout ss", 32'(ok), 32'd1);
    checkOutput("tout owner", 32'(owner_o), 32'd1);
    checkOutput("tout ack", 32'(ack_o), 32'b0010);
    checkOutput("tout data", 32'(uart_data_o), 32'h4B);
    applyStimulus(4'b0000, 4'b0000);
    repeat (63) tick();
    checkOutput("tout early", 32'(timeout_err_o), 32'd0);
    tick();
    checkOutput("tout pulse", 32'(timeout_err_o), 32'd1);
    tick();
    checkOutput("tout pulse end", 32'(timeout_err_o), 32'd0);
    checkOutput("tout active gap", 32'(active_o), 32'd1);
    tick();
    checkOutput("tout active end", 32'(active_o), 32'd0);
    busyModelOn = 1'b1;
    setData(0, 8'h99);
    applyStimulus(4'b0001, 4'b0000);
    waitSs(40, ok);
    checkOutput("post tout ss", 32'(ok), 32'd1);
    checkOutput("post tout owner", 32'(owner_o), 32'd0);
    checkOutput("post tout data", 32'(uart_data_o), 32'h99);
    applyStimulus(4'b0000, 4'b0000);
    waitIdle(40, ok);
    checkOutput("post tout idle", 32'(ok), 32'd1);

    $display("[TB] reset mid-transfer");
    setData(2, 8'h5A);
    applyStimulus(4'b0100, 4'b0000);
    waitSs(40, ok);
    checkOutput("mid ss", 32'(ok), 32'd1);
    checkOutput("mid owner", 32'(owner_o), 32'd2);
    applyStimulus(4'b0000, 4'b0000);
    repeat (4) tick();
    checkOutput("mid active before", 32'(active_o), 32'd1);
    reset_i = 1'b1;
    #1;
    checkOutput("mid rst active", 32'(active_o), 32'd0);
    checkOutput("mid rst owner", 32'(owner_o), 32'd3);
    checkOutput("mid rst ss", 32'(uart_ss_o), 32'd0);
    checkOutput("mid rst ack", 32'(ack_o), 32'd0);
    checkOutput("mid rst data", 32'(uart_data_o), 32'd0);
    tick();
    tick();
    reset_i = 1'b0;
    setData(3, 8'h77);
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("after rst ss early", 32'(uart_ss_o), 32'd0);
    tick();
    checkOutput("after rst ss", 32'(uart_ss_o), 32'd1);
    checkOutput("after rst owner", 32'(owner_o), 32'd3);
    checkOutput("after rst data", 32'(uart_data_o), 32'h77);
    checkOutput("after rst ack", 32'(ack_o), 32'b1000);
    applyStimulus(4'b0000, 4'b0000);
    waitIdle(40, ok);
    checkOutput("after rst idle", 32'(ok), 32'd1);

    checkOutput("total ss", 32'(ssSeen), 32'd14);
    checkOutput("total ack", 32'(ackSeen), 32'd14);
    checkOutput("ack without ss", 32'(ackStray), 32'd0);
    checkOutput("multi-bit ack", 32'(multiAck), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
